// File: rtl/conv_mac_unit.sv
// 3x3 convolution MAC: snapshots window and kernel on start, then one product per cycle.
// Result 10 cycles after start is sampled; start is ignored while busy (no queueing), so throughput is one result per 10 cycles.
module conv_mac_unit #(
    parameter int SATURATE = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [35:0] sample_in,
    input  logic [35:0] kernel_in,
    output logic        busy,
    output logic        result_valid,
    output logic [11:0] raw_sum,
    output logic [7:0]  pixel_out
);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t             state_q;
    logic [35:0]        sample_q;
    logic [35:0]        kernel_q;
    logic signed [11:0] acc_q;
    logic [3:0]         idx_q;

    logic [3:0]         pix_cur;
    logic [3:0]         coef_cur;
    logic signed [11:0] prod;
    logic signed [11:0] acc_d;
    logic [7:0]         pix_map;

    // Pixel is unsigned, coefficient signed; both widened to 12 bits so the
    // product and the running sum stay in accumulator width (|sum| <= 1080).
    always_comb begin
        pix_cur  = sample_q[{idx_q, 2'b00} +: 4];
        coef_cur = kernel_q[{idx_q, 2'b00} +: 4];
        prod     = $signed({8'b0, pix_cur}) * $signed({{8{coef_cur[3]}}, coef_cur});
        acc_d    = acc_q + prod;
    end

    always_comb begin
        pix_map = acc_d[7:0];
        if (SATURATE != 0) begin
            if (acc_d[11]) begin
                pix_map = 8'd0;
            end else if (acc_d[11:8] != 4'd0) begin
                pix_map = 8'd255;
            end
        end
    end

    assign busy = (state_q == MAC);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            kernel_q     <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            result_valid <= 1'b0;
            raw_sum      <= '0;
            pixel_out    <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sample_q <= sample_in;
                        kernel_q <= kernel_in;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        state_q  <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == 4'd8) begin
                        idx_q        <= '0;
                        raw_sum      <= acc_d;
                        pixel_out    <= pix_map;
                        result_valid <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit: both SATURATE settings side by side, scoreboard of expected results.
module tb_conv_mac_unit;

    typedef struct packed {
        logic [11:0] raw;
        logic [7:0]  p_sat;
        logic [7:0]  p_raw;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [35:0] sample_in;
    logic [35:0] kernel_in;

    logic        busy_s, rv_s, busy_r, rv_r;
    logic [11:0] raw_s, raw_r;
    logic [7:0]  pix_s, pix_r;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t sb[$];

    conv_mac_unit #(.SATURATE(1)) dut_sat (
        .clk(clk), .n_rst(n_rst), .start(start),
        .sample_in(sample_in), .kernel_in(kernel_in),
        .busy(busy_s), .result_valid(rv_s), .raw_sum(raw_s), .pixel_out(pix_s)
    );

    conv_mac_unit #(.SATURATE(0)) dut_raw (
        .clk(clk), .n_rst(n_rst), .start(start),
        .sample_in(sample_in), .kernel_in(kernel_in),
        .busy(busy_r), .result_valid(rv_r), .raw_sum(raw_r), .pixel_out(pix_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [35:0] s, input logic [35:0] k);
        int   acc;
        exp_t e;
        logic [31:0] acc_v;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            acc += int'(s[4*i +: 4]) * int'($signed(k[4*i +: 4]));
        end
        acc_v   = acc;
        e.raw   = acc_v[11:0];
        e.p_raw = acc_v[7:0];
        if (acc < 0)        e.p_sat = 8'd0;
        else if (acc > 255) e.p_sat = 8'd255;
        else                e.p_sat = acc_v[7:0];
        return e;
    endfunction

    // Result monitor: every completion must match the oldest expected entry.
    always @(negedge clk) begin
        if (n_rst && rv_s) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("FAIL unexpected_result: observed raw %0h expected no result", raw_s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("raw_sum_sat", 32'(raw_s), 32'(e.raw));
                chk("raw_sum_raw", 32'(raw_r), 32'(e.raw));
                chk("pixel_sat", 32'(pix_s), 32'(e.p_sat));
                chk("pixel_raw", 32'(pix_r), 32'(e.p_raw));
                chk("rv_match", 32'(rv_r), 32'd1);
            end
        end
    end

    task automatic run_op(input logic [35:0] s, input logic [35:0] k,
                          input bit scramble, input bit poke);
        int  busy_cnt;
        int  lat;
        bit  got;
        busy_cnt = 0;
        lat      = 0;
        got      = 1'b0;
        @(negedge clk);
        sample_in = s;
        kernel_in = k;
        start     = 1'b1;
        sb.push_back(model(s, k));
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            start = poke && (c >= 2) && (c <= 6);
            if (scramble) begin
                sample_in = 36'({$urandom(), $urandom()});
                kernel_in = 36'({$urandom(), $urandom()});
            end
            if (busy_s) busy_cnt++;
            if (rv_s) begin
                got = 1'b1;
                lat = c;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'd10);
        chk("busy_cycles", 32'(busy_cnt), 32'd9);
    endtask

    initial begin
        int   nres;
        int   prev;
        exp_t e;
        logic [11:0] held;

        n_rst     = 1'b0;
        start     = 1'b0;
        sample_in = '0;
        kernel_in = '0;
        #1;
        chk("reset_busy", 32'(busy_s), 32'd0);
        chk("reset_rv", 32'(rv_s), 32'd0);
        chk("reset_raw", 32'(raw_s), 32'd0);
        chk("reset_pix", 32'(pix_s), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Basic sum, both extremes, identity kernel with scrambled inputs and
        // ignored start pulses, then two random windows.
        run_op(36'h111111111, 36'h111111111, 1'b0, 1'b0);
        run_op(36'hFFFFFFFFF, 36'h777777777, 1'b0, 1'b0);
        run_op(36'hFFFFFFFFF, 36'h888888888, 1'b0, 1'b0);
        run_op(36'hFFFFAFFFF, 36'h000010000, 1'b1, 1'b1);
        repeat (15) @(negedge clk);
        chk("hold_raw", 32'(raw_s), 32'd10);
        chk("hold_pix", 32'(pix_s), 32'd10);
        chk("idle_after_poke", 32'(busy_s), 32'd0);
        run_op(36'h3A5C7E91B, 36'h9F01E72C4, 1'b0, 1'b0);
        run_op(36'h0123456789 & 36'hFFFFFFFFF, 36'hF1E2D3C4B, 1'b1, 1'b0);
        held = raw_s;

        // Abort mid-operation: asserted after index 4 is reached, no result.
        @(negedge clk);
        sample_in = 36'h999999999;
        kernel_in = 36'h333333333;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", 32'(busy_s), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_s), 32'd0);
        chk("abort_rv", 32'(rv_s), 32'd0);
        chk("abort_raw", 32'(raw_s), 32'd0);
        chk("abort_pix", 32'(pix_s), 32'd0);
        chk("abort_pix_raw", 32'(pix_r), 32'd0);
        chk("prior_raw_nonzero", 32'(held != 12'd0), 32'd1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_result_busy", 32'(busy_s), 32'd0);
        run_op(36'h222222222, 36'h123456712, 1'b0, 1'b0);

        // Start held high: back-to-back operations every 10 cycles.
        @(negedge clk);
        sample_in = 36'h5A5A5A5A5;
        kernel_in = 36'h7F7F7F7F7;
        start     = 1'b1;
        sb.push_back(model(sample_in, kernel_in));
        nres = 0;
        prev = 0;
        for (int c = 1; c <= 40 && nres < 3; c++) begin
            @(negedge clk);
            if (rv_s) begin
                nres++;
                chk("cont_interval", 32'(c - prev), 32'd10);
                prev = c;
                if (nres < 3) begin
                    sample_in = 36'({$urandom(), $urandom()});
                    kernel_in = 36'({$urandom(), $urandom()});
                    e = model(sample_in, kernel_in);
                    sb.push_back(e);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("cont_results", 32'(nres), 32'd3);

        repeat (15) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
